// File: rtl/button_cmd_pkg.sv
// Shared types and helpers for the button command decoder: FSM states,
// one-hot test and millisecond-to-cycle conversion.
package button_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRESS  = 2'd1,
    ST_REPEAT = 2'd2
  } t_bcd_state;

  function automatic logic is_one_hot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  function automatic logic [31:0] ms_to_cycles(input int unsigned fclk,
                                               input int unsigned ms);
    return 32'((fclk / 1000) * ms);
  endfunction

endpackage

// File: rtl/button_cmd_decoder.sv
// Turns the debounced one-hot button levels into single-cycle press, long,
// repeat and release events; one button is tracked at a time.
module button_cmd_decoder
  import button_cmd_pkg::*;
#(
  parameter int unsigned FCLK      = 20000000,
  parameter int unsigned HOLD_MS   = 1000,
  parameter int unsigned REPEAT_MS = 200
) (
  input  logic       i_clk_mhz,
  input  logic       i_rst_mhz,
  input  logic [3:0] i_btns_deb,
  output logic [3:0] o_btn_press,
  output logic [3:0] o_btn_long,
  output logic [3:0] o_btn_repeat,
  output logic [3:0] o_btn_release,
  output logic [3:0] o_btn_active
);

  localparam logic [31:0] C_HOLD = ms_to_cycles(FCLK, HOLD_MS);
  localparam logic [31:0] C_REP  = ms_to_cycles(FCLK, REPEAT_MS);

  if (FCLK < 1000) begin : g_chk_fclk
    $error("button_cmd_decoder: FCLK must be >= 1000");
  end
  if (HOLD_MS < 1) begin : g_chk_hold
    $error("button_cmd_decoder: HOLD_MS must be >= 1");
  end
  if (REPEAT_MS < 1) begin : g_chk_rep
    $error("button_cmd_decoder: REPEAT_MS must be >= 1");
  end

  t_bcd_state  s_state;
  logic [31:0] s_t;
  logic [31:0] s_t_inc;
  logic [3:0]  s_store;
  logic        s_armed;

  always_comb begin
    s_t_inc = s_t;
    if (s_t < C_HOLD - 32'd1) begin
      s_t_inc = s_t + 32'd1;
    end
  end

  // Release is tested before the timer so it wins over long/repeat.
  always_ff @(posedge i_clk_mhz or posedge i_rst_mhz) begin
    if (i_rst_mhz) begin
      s_state       <= ST_IDLE;
      s_t           <= '0;
      s_store       <= '0;
      s_armed       <= 1'b0;
      o_btn_press   <= '0;
      o_btn_long    <= '0;
      o_btn_repeat  <= '0;
      o_btn_release <= '0;
      o_btn_active  <= '0;
    end else begin
      o_btn_press   <= '0;
      o_btn_long    <= '0;
      o_btn_repeat  <= '0;
      o_btn_release <= '0;
      if (i_btns_deb == 4'b0000) begin
        s_armed <= 1'b1;
      end

      case (s_state)
        ST_IDLE: begin
          if (is_one_hot4(i_btns_deb) && s_armed) begin
            s_store      <= i_btns_deb;
            o_btn_press  <= i_btns_deb;
            o_btn_active <= i_btns_deb;
            s_armed      <= 1'b0;
            s_t          <= '0;
            s_state      <= ST_PRESS;
          end else begin
            s_t <= s_t_inc;
          end
        end

        ST_PRESS: begin
          if (i_btns_deb != s_store) begin
            o_btn_release <= s_store;
            o_btn_active  <= '0;
            s_t           <= '0;
            s_state       <= ST_IDLE;
          end else if (s_t == C_HOLD - 32'd1) begin
            o_btn_long <= s_store;
            s_t        <= '0;
            s_state    <= ST_REPEAT;
          end else begin
            s_t <= s_t_inc;
          end
        end

        ST_REPEAT: begin
          if (i_btns_deb != s_store) begin
            o_btn_release <= s_store;
            o_btn_active  <= '0;
            s_t           <= '0;
            s_state       <= ST_IDLE;
          end else if (s_t == C_REP - 32'd1) begin
            o_btn_repeat <= s_store;
            s_t          <= '0;
          end else begin
            s_t <= s_t_inc;
          end
        end

        default: begin
          o_btn_active <= '0;
          s_t          <= '0;
          s_state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_cmd_decoder.sv
// Self-checking bench for button_cmd_decoder: directed vector table, timed
// long/repeat and reset sequences, and random stimulus against an age-based model.
module tb_button_cmd_decoder;

  localparam int HOLD = 10;
  localparam int REP  = 4;

  logic       i_clk_mhz = 1'b0;
  logic       i_rst_mhz = 1'b1;
  logic [3:0] i_btns_deb = 4'b0000;
  logic [3:0] o_btn_press, o_btn_long, o_btn_repeat, o_btn_release, o_btn_active;

  button_cmd_decoder #(
    .FCLK      (1000),
    .HOLD_MS   (10),
    .REPEAT_MS (4)
  ) dut (
    .i_clk_mhz     (i_clk_mhz),
    .i_rst_mhz     (i_rst_mhz),
    .i_btns_deb    (i_btns_deb),
    .o_btn_press   (o_btn_press),
    .o_btn_long    (o_btn_long),
    .o_btn_repeat  (o_btn_repeat),
    .o_btn_release (o_btn_release),
    .o_btn_active  (o_btn_active)
  );

  always #5 i_clk_mhz = ~i_clk_mhz;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: which button is held, how many cycles since its press pulse,
  // and whether the input has been seen idle since the last accepted press.
  logic [3:0] m_tracked = 4'b0000;
  int         m_age     = 0;
  bit         m_armed   = 1'b0;
  logic [19:0] m_exp    = '0;

  function automatic logic [19:0] dut_vec();
    return {o_btn_press, o_btn_long, o_btn_repeat, o_btn_release, o_btn_active};
  endfunction

  task automatic check(input string name, input logic [19:0] got, input logic [19:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got p/l/r/x/a=%h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic [3:0] v);
    logic [3:0] p, l, r, x;
    p = '0; l = '0; r = '0; x = '0;
    if (m_tracked != 4'b0000) begin
      if (v != m_tracked) begin
        x = m_tracked;
        m_tracked = 4'b0000;
      end else begin
        m_age++;
        if (m_age == HOLD) l = m_tracked;
        else if (m_age > HOLD && ((m_age - HOLD) % REP) == 0) r = m_tracked;
      end
    end else if ($countones(v) == 1 && m_armed) begin
      p = v;
      m_tracked = v;
      m_age = 0;
      m_armed = 1'b0;
    end
    if (v == 4'b0000) m_armed = 1'b1;
    m_exp = {p, l, r, x, m_tracked};
  endtask

  task automatic apply(input logic [3:0] v, input string name);
    i_btns_deb = v;
    @(posedge i_clk_mhz);
    model_step(v);
    #1;
    check(name, dut_vec(), m_exp);
  endtask

  task automatic model_reset();
    m_tracked = 4'b0000;
    m_age     = 0;
    m_armed   = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  in;
    logic [19:0] exp;
  } vec_t;

  vec_t tbl[16];
  int   press_at, long_at, pulses;
  int   rep_q[$];

  initial begin
    // {press, long, repeat, release, active}
    tbl[0]  = '{4'b0000, 20'h00000};
    tbl[1]  = '{4'b0010, 20'h20002};
    tbl[2]  = '{4'b0010, 20'h00002};
    tbl[3]  = '{4'b0010, 20'h00002};
    tbl[4]  = '{4'b0010, 20'h00002};
    tbl[5]  = '{4'b0010, 20'h00002};
    tbl[6]  = '{4'b0000, 20'h00020};
    tbl[7]  = '{4'b0110, 20'h00000};
    tbl[8]  = '{4'b1111, 20'h00000};
    tbl[9]  = '{4'b0000, 20'h00000};
    tbl[10] = '{4'b0001, 20'h10001};
    tbl[11] = '{4'b0010, 20'h00010};
    tbl[12] = '{4'b0010, 20'h00000};
    tbl[13] = '{4'b0000, 20'h00000};
    tbl[14] = '{4'b0010, 20'h20002};
    tbl[15] = '{4'b0000, 20'h00020};

    // Reset state
    i_rst_mhz = 1'b1;
    repeat (2) @(posedge i_clk_mhz);
    #1;
    check("reset_state", dut_vec(), 20'h00000);
    @(negedge i_clk_mhz);
    i_rst_mhz = 1'b0;
    model_reset();

    // Directed table: short press, invalid codes, direct switch
    for (int unsigned i = 0; i < 16; i++) begin
      i_btns_deb = tbl[i].in;
      @(posedge i_clk_mhz);
      model_step(tbl[i].in);
      #1;
      check($sformatf("table_%0d", i), dut_vec(), tbl[i].exp);
      check($sformatf("table_model_%0d", i), dut_vec(), m_exp);
    end

    // Long press with repeats
    apply(4'b0000, "lp_idle");
    press_at = -1; long_at = -1;
    rep_q.delete();
    for (int i = 0; i < 30; i++) begin
      apply(4'b0100, "lp_hold");
      if (o_btn_press != 4'b0000) press_at = i;
      if (o_btn_long != 4'b0000) long_at = i;
      if (o_btn_repeat != 4'b0000) rep_q.push_back(i);
    end
    check("lp_press_at", 20'(press_at), 20'd0);
    check("lp_long_offset", 20'(long_at - press_at), 20'd10);
    check("lp_repeat_count", 20'(rep_q.size()), 20'd4);
    for (int k = 0; k < rep_q.size() && k < 4; k++)
      check($sformatf("lp_repeat_offset_%0d", k), 20'(rep_q[k] - press_at), 20'(14 + 4 * k));
    apply(4'b0000, "lp_release");
    check("lp_release_val", {16'h0, o_btn_release}, 20'h00004);

    // Invalid inputs held from idle
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      apply(4'b0110, "inv_0110");
      pulses += (dut_vec() != 20'h0) ? 1 : 0;
    end
    for (int i = 0; i < 20; i++) begin
      apply(4'b1111, "inv_1111");
      pulses += (dut_vec() != 20'h0) ? 1 : 0;
    end
    check("inv_activity", 20'(pulses), 20'd0);
    apply(4'b0000, "inv_idle");

    // Held across reset
    i_btns_deb = 4'b1000;
    i_rst_mhz = 1'b1;
    @(posedge i_clk_mhz);
    @(negedge i_clk_mhz);
    i_rst_mhz = 1'b0;
    model_reset();
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      apply(4'b1000, "held_rst");
      pulses += (dut_vec() != 20'h0) ? 1 : 0;
    end
    check("held_rst_activity", 20'(pulses), 20'd0);
    apply(4'b0000, "held_rst_idle");
    apply(4'b1000, "held_rst_press");
    check("held_rst_press_val", {16'h0, o_btn_press}, 20'h00008);
    apply(4'b0000, "held_rst_rel");

    // Asynchronous reset during repeat phase
    apply(4'b0001, "ar_press");
    for (int i = 0; i < 15; i++) apply(4'b0001, "ar_hold");
    check("ar_active_before", {16'h0, o_btn_active}, 20'h00001);
    #2;
    i_rst_mhz = 1'b1;
    #1;
    check("ar_async_clear", dut_vec(), 20'h00000);
    model_reset();
    @(posedge i_clk_mhz);
    #1;
    i_rst_mhz = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      apply(4'b0001, "ar_after");
      pulses += (o_btn_release != 4'b0000) ? 1 : 0;
    end
    check("ar_no_release", 20'(pulses), 20'd0);
    apply(4'b0000, "ar_idle");
    apply(4'b0001, "ar_repress");

    // Random stimulus against the model
    for (int seg = 0; seg < 120; seg++) begin
      logic [3:0] v;
      int unsigned sel, len;
      sel = $urandom_range(0, 9);
      if (sel < 3)      v = 4'b0000;
      else if (sel < 8) v = 4'b0001 << $urandom_range(0, 3);
      else              v = 4'($urandom);
      len = (sel >= 3 && sel < 6) ? $urandom_range(8, 24) : $urandom_range(1, 5);
      for (int unsigned c = 0; c < len; c++) apply(v, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
